spi_frame_rx: RTL

Synchronous SPI slave front-end, directly upstream of the register bank. Oversamples the MCU SPI lines (SCK, CS, MOSI, SPECIAL) in the XTALCLK domain and counts bits per frame. Emits one validated write strobe carrying the 8-bit address and 8-bit value only when a frame holds exactly FRAME_BITS bits. Replaces direct use of the SPI clock and CS as fabric clocks, so the register bank becomes a plain clk-domain consumer.

---
 rtl/spi_regs_pkg.sv | 19 +
 rtl/spi_in_sync.sv | 36 +++
 rtl/spi_frame_rx.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_regs_pkg.sv
// Shared constants and types for the SPI frame receiver and the register bank behind it.
package spi_regs_pkg;

   localparam int unsigned FRAME_BITS  = 16;
   localparam int unsigned ADDR_BITS   = 8;
   localparam int unsigned SYNC_STAGES = 2;

   // Register addresses decoded by the downstream register bank
   localparam logic [7:0] REG_LED    = 8'h07;
   localparam logic [7:0] REG_MUX    = 8'h08;
   localparam logic [7:0] REG_ERRCLR = 8'hFF;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } rx_state_e;

endpackage

// File: rtl/spi_in_sync.sv
// Synchronizer for one asynchronous SPI line: SyncStages flops plus a history flop.
// Edges are reported for exactly one clk when the synchronized level changes.
module spi_in_sync #(
   parameter int unsigned SyncStages = 2,
   parameter logic        ResetVal   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SyncStages-1:0] sync_q;
   logic                  hist_q;

   // Shift the async input through the chain; history holds the previous synchronized level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {SyncStages{ResetVal}};
         hist_q <= ResetVal;
      end else begin
         sync_q <= {sync_q[SyncStages-2:0], d_i};
         hist_q <= sync_q[SyncStages-1];
      end
   end

   // Level and edge detection from the last sync stage against history
   always_comb begin
      level_o = sync_q[SyncStages-1];
      rise_o  = sync_q[SyncStages-1] & ~hist_q;
      fall_o  = ~sync_q[SyncStages-1] & hist_q;
   end

endmodule

// File: rtl/spi_frame_rx.sv
// SPI slave front-end: oversamples SCK/CS/MOSI/SPECIAL in the clk domain, collects one frame
// per CS-low window and emits a single write strobe when the frame has exactly FrameBits bits.
// Optional error counter output err_count_o is present when SPI_FRAME_ERR_CNT_EN is defined.
module spi_frame_rx
   import spi_regs_pkg::*;
#(
   parameter int unsigned FrameBits  = FRAME_BITS,
   parameter int unsigned AddrBits   = ADDR_BITS,
   parameter int unsigned SyncStages = SYNC_STAGES
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          spi_sck_i,
   input  logic                          spi_cs_i,
   input  logic                          spi_mosi_i,
   input  logic                          spi_special_i,
   output logic                          wr_valid_o,
   output logic [AddrBits-1:0]           wr_addr_o,
   output logic [FrameBits-AddrBits-1:0] wr_data_o,
   output logic                          frame_err_o,
`ifdef SPI_FRAME_ERR_CNT_EN
   output logic [7:0]                    err_count_o,
`endif
   output logic                          busy_o
);

   localparam int unsigned DataBits = FrameBits - AddrBits;
   // Count must hold FrameBits+1 so an overlong frame can never wrap onto FrameBits
   localparam int unsigned CntW     = $clog2(FrameBits + 2);

   logic sck_fall, cs_rise, cs_fall, mosi_level, spc_level, spc_rise;
   logic unused_sync;
   logic sck_level_unused, sck_rise_unused, cs_level_unused;
   logic mosi_rise_unused, mosi_fall_unused, spc_fall_unused;

   rx_state_e             state_q, state_d;
   logic [FrameBits-1:0]  shift_q, shift_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  pend_q, pend_d;
   logic                  wr_valid_q, wr_valid_d;
   logic                  frame_err_q, frame_err_d;
   logic [AddrBits-1:0]   wr_addr_q, wr_addr_d;
   logic [DataBits-1:0]   wr_data_q, wr_data_d;

   spi_in_sync #(.SyncStages(SyncStages), .ResetVal(1'b1)) u_sync_sck (
      .clk     (clk),
      .rst     (rst),
      .d_i     (spi_sck_i),
      .level_o (sck_level_unused),
      .rise_o  (sck_rise_unused),
      .fall_o  (sck_fall)
   );

   spi_in_sync #(.SyncStages(SyncStages), .ResetVal(1'b1)) u_sync_cs (
      .clk     (clk),
      .rst     (rst),
      .d_i     (spi_cs_i),
      .level_o (cs_level_unused),
      .rise_o  (cs_rise),
      .fall_o  (cs_fall)
   );

   spi_in_sync #(.SyncStages(SyncStages), .ResetVal(1'b0)) u_sync_mosi (
      .clk     (clk),
      .rst     (rst),
      .d_i     (spi_mosi_i),
      .level_o (mosi_level),
      .rise_o  (mosi_rise_unused),
      .fall_o  (mosi_fall_unused)
   );

   spi_in_sync #(.SyncStages(SyncStages), .ResetVal(1'b0)) u_sync_spc (
      .clk     (clk),
      .rst     (rst),
      .d_i     (spi_special_i),
      .level_o (spc_level),
      .rise_o  (spc_rise),
      .fall_o  (spc_fall_unused)
   );

   // Collect the synchronizer outputs this block has no use for
   always_comb begin
      unused_sync = ^{sck_level_unused, sck_rise_unused, cs_level_unused,
                      mosi_rise_unused, mosi_fall_unused, spc_fall_unused};
   end

   // Next-state logic: frame collection, validation and strobe generation
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      pend_d      = pend_q;
      wr_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      unique case (state_q)
         StIdle: begin
            pend_d = 1'b0;
            // pend_q carries a CS fall that arrived while DONE was being handled
            if ((cs_fall && !spc_level) || pend_q) begin
               state_d = StShift;
               shift_d = '0;
               cnt_d   = '0;
            end
         end
         StShift: begin
            if (spc_rise) begin
               state_d     = StIdle;
               frame_err_d = 1'b1;
            end else begin
               // A bit arriving in the same clk as CS rising still belongs to this frame
               if (sck_fall) begin
                  shift_d = {shift_q[FrameBits-2:0], mosi_level};
                  if (cnt_q != CntW'(FrameBits + 1)) begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               if (cs_rise) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            if (cnt_q == CntW'(FrameBits)) begin
               wr_valid_d = 1'b1;
               wr_addr_d  = shift_q[FrameBits-1 -: AddrBits];
               wr_data_d  = shift_q[DataBits-1:0];
            end else begin
               frame_err_d = 1'b1;
            end
            if (cs_fall && !spc_level) begin
               pend_d = 1'b1;
            end
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         shift_q     <= '0;
         cnt_q       <= '0;
         pend_q      <= 1'b0;
         wr_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         wr_valid_q  <= wr_valid_d;
         frame_err_q <= frame_err_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

`ifdef SPI_FRAME_ERR_CNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   // Saturating error counter, cleared by a valid write to the error-clear address
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (frame_err_d) begin
         if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
      end else if (wr_valid_d && (wr_addr_d == AddrBits'(REG_ERRCLR))) begin
         err_cnt_d = 8'h00;
      end
   end

   // Error counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_q <= 8'h00;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_count_o = err_cnt_q;
`endif

   // Registered outputs; busy reflects frame collection in progress
   always_comb begin
      wr_valid_o  = wr_valid_q;
      frame_err_o = frame_err_q;
      wr_addr_o   = wr_addr_q;
      wr_data_o   = wr_data_q;
      busy_o      = (state_q == StShift);
   end

endmodule
